// File: rtl/axi_ddr_pattern_checker_if.sv
// AXI4 read-only channel bundle (AR + R) between the pattern checker and the NoC port.
// Both channels use standard AXI valid/ready: a beat transfers on a rising clock edge where valid and ready are both high; once valid is raised, the source holds it and its payload stable until that edge.
interface axi_ddr_pattern_checker_if #(
   parameter int ADDR_W = 44,
   parameter int DATA_W = 128
);
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [3:0]        arcache;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output araddr, arlen, arsize, arburst, arcache, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arcache, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_ddr_pattern_checker.sv
// Reads a DDR region back in 64-byte INCR bursts and checks each 32-bit word against an
// address-as-data pattern; reports pass/fail, error count, first failing address and a level irq.
module axi_ddr_pattern_checker #(
   parameter int ADDR_W      = 44,
   parameter int DATA_W      = 128,
   parameter int BURST_BEATS = 4,
   parameter int CNT_W       = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         dst_base,
   input  logic [31:0]               pattern_base,
   input  logic [CNT_W-1:0]          byte_count,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [15:0]               err_count,
   output logic [ADDR_W-1:0]         first_err_addr,
   output logic                      resp_err,
   output logic                      irq,
   input  logic                      irq_clr,
   output logic [1:0]                state_dbg,
   axi_ddr_pattern_checker_if.master m_axi
);
   localparam int LANES  = DATA_W / 32;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);
   localparam logic [CNT_W-1:0]  BURST_BYTES = CNT_W'(64);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_FIN = 2'd3} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d, araddr_q, araddr_d, first_q, first_d;
   logic [31:0]         pat_q, pat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, off_q, off_d, off_inc;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [15:0]         err_q, err_d, err_sat;
   logic                first_vld_q, first_vld_d, resp_err_q, resp_err_d;
   logic                pass_q, pass_d, irq_q, irq_d, busy_q, busy_d, pass_now;

   logic [ADDR_W-1:0]   beat_addr, fail_addr;
   logic [31:0]         beat_pat;
   logic [LANES-1:0]    lane_bad;
   logic [LANE_W-1:0]   first_lane;
   logic [3:0]          lane_errs, beat_errs;
   logic [16:0]         err_sum;
   logic                resp_bad, last_bad;

   // Alignment bits of the base and count are dropped by design.
   logic unused_align;
   assign unused_align = &{1'b0, dst_base[5:0], byte_count[5:0]};

   assign off_inc  = off_q + BURST_BYTES;
   assign pass_now = (err_q == 16'd0) && !resp_err_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = (byte_count[CNT_W-1:6] == '0) ? S_FIN : S_AR;
         S_AR:   if (m_axi.arready) state_d = S_R;
         S_R:    if (m_axi.rvalid && beat_q == LAST_BEAT)
                    state_d = (off_inc < cnt_q) ? S_AR : S_FIN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin : outputs
      m_axi.araddr   = araddr_q;
      m_axi.arlen    = 8'(BURST_BEATS - 1);
      m_axi.arsize   = 3'h4;
      m_axi.arburst  = 2'b01;
      m_axi.arcache  = 4'hF;
      m_axi.arvalid  = (state_q == S_AR);
      m_axi.rready   = (state_q == S_R);
      done           = (state_q == S_FIN);
      busy           = busy_q;
      pass           = done ? pass_now : pass_q;
      irq            = irq_q | done;
      err_count      = err_q;
      first_err_addr = first_q;
      resp_err       = resp_err_q;
      state_dbg      = state_q;
   end

   // Per-beat evaluation; only consumed while a beat is accepted in S_R.
   always_comb begin : beat_eval
      beat_addr  = base_q + ADDR_W'(off_q) + ADDR_W'({beat_q, 4'b0000});
      beat_pat   = pat_q + 32'(off_q) + 32'({beat_q, 4'b0000});
      lane_bad   = '0;
      first_lane = '0;
      lane_errs  = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (m_axi.rdata[32*k +: 32] != beat_pat + 32'(4 * k)) begin
            lane_bad[k] = 1'b1;
            first_lane  = LANE_W'(k);
            lane_errs   = lane_errs + 4'd1;
         end
      end
      resp_bad  = (m_axi.rresp != 2'b00);
      last_bad  = (m_axi.rlast != (beat_q == LAST_BEAT));
      beat_errs = (resp_bad ? 4'd1 : lane_errs) + (last_bad ? 4'd1 : 4'd0);
      if (resp_bad || lane_bad == '0) fail_addr = beat_addr;
      else                            fail_addr = beat_addr + ADDR_W'({first_lane, 2'b00});
      err_sum = {1'b0, err_q} + 17'(beat_errs);
      err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_comb begin : datapath
      base_d      = base_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      beat_d      = beat_q;
      araddr_d    = araddr_q;
      err_d       = err_q;
      first_d     = first_q;
      first_vld_d = first_vld_q;
      resp_err_d  = resp_err_q;
      pass_d      = pass_q;
      irq_d       = irq_q;
      busy_d      = busy_q;
      if (irq_clr) irq_d = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            base_d      = {dst_base[ADDR_W-1:6], 6'b0};
            araddr_d    = {dst_base[ADDR_W-1:6], 6'b0};
            pat_d       = pattern_base;
            cnt_d       = {byte_count[CNT_W-1:6], 6'b0};
            off_d       = '0;
            beat_d      = '0;
            err_d       = '0;
            first_d     = '0;
            first_vld_d = 1'b0;
            resp_err_d  = 1'b0;
            pass_d      = 1'b0;
            irq_d       = 1'b0;
            busy_d      = 1'b1;
         end
         S_R: if (m_axi.rvalid) begin
            err_d = err_sat;
            if (resp_bad || last_bad) resp_err_d = 1'b1;
            if (beat_errs != 4'd0 && !first_vld_q) begin
               first_d     = fail_addr;
               first_vld_d = 1'b1;
            end
            if (beat_q == LAST_BEAT) begin
               beat_d   = '0;
               off_d    = off_inc;
               araddr_d = base_q + ADDR_W'(off_inc);
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         // Setting irq here outranks an irq_clr arriving in the done cycle.
         S_FIN: begin
            busy_d = 1'b0;
            pass_d = pass_now;
            irq_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         base_q      <= '0;
         pat_q       <= '0;
         cnt_q       <= '0;
         off_q       <= '0;
         beat_q      <= '0;
         araddr_q    <= '0;
         err_q       <= '0;
         first_q     <= '0;
         first_vld_q <= 1'b0;
         resp_err_q  <= 1'b0;
         pass_q      <= 1'b0;
         irq_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         base_q      <= base_d;
         pat_q       <= pat_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         beat_q      <= beat_d;
         araddr_q    <= araddr_d;
         err_q       <= err_d;
         first_q     <= first_d;
         first_vld_q <= first_vld_d;
         resp_err_q  <= resp_err_d;
         pass_q      <= pass_d;
         irq_q       <= irq_d;
         busy_q      <= busy_d;
      end
   end
endmodule
